posit_mac_feeder: RTL

- Upstream operand sequencer for the posit MAC (WIDTH=8, EXP=1, K=9).
- Holds a K-entry weight register file and a K-entry activation line buffer filled over a valid/ready handshake.
- Issues each dot product as one contiguous K-beat burst of {vld_o, win_o, din_o}, then enforces a drain gap.
- Counts results returned by the MAC (its vld_o) and caps outstanding dot products.

---
 rtl/posit_mac_pkg.sv | 22 ++
 rtl/posit_mac_regfile.sv | 35 +++
 rtl/posit_mac_feeder.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/posit_mac_pkg.sv
// Shared definitions for the posit MAC operand feeder.
// Holds MAC geometry defaults, the feeder state encoding and the MAC drain
// latency used as the default inter-burst gap.
package posit_mac_pkg;

  // Posit format and dot-product length of the attached MAC
  localparam int unsigned WIDTH_DEF = 8;
  localparam int unsigned EXP_DEF   = 1;
  localparam int unsigned K_DEF     = 9;

  // Depth of the MAC valid pipeline (vld_d); a new burst must wait this long
  localparam int unsigned MAC_DRAIN = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD_W = 3'd1,
    ST_FILL   = 3'd2,
    ST_BURST  = 3'd3,
    ST_GAP    = 3'd4
  } feeder_state_e;

endpackage

// File: rtl/posit_mac_regfile.sv
// DEPTH x WIDTH register array, one synchronous write port and one
// asynchronous read port. Contents are not reset.
// Ports:
//   clk      clock
//   we       write enable
//   waddr    write address
//   wdata    write data
//   raddr    read address
//   rdata_c  read data (combinational from raddr)
module posit_mac_regfile #(
  parameter  int unsigned WIDTH = 8,
  parameter  int unsigned DEPTH = 9,
  localparam int unsigned WA    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [WA-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [WA-1:0]    raddr,
  output logic [WIDTH-1:0] rdata_c
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port
  assign rdata_c = mem[raddr];

endmodule

// File: rtl/posit_mac_feeder.sv
// Operand sequencer for the posit MAC: loads a K-entry weight file, buffers
// K activations, then issues one contiguous K-beat burst followed by a drain
// gap, while limiting the number of dot products in flight.
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   w_load_i       start a weight load (K beats follow on w_vld_i)
//   w_vld_i        weight beat valid
//   w_data_i       weight posit
//   a_vld_i        activation valid
//   a_data_i       activation posit
//   a_rdy_o        activation ready
//   mac_vld_i      one-cycle result strobe from the MAC
//   vld_o          beat valid to the MAC
//   win_o          weight to the MAC
//   din_o          activation to the MAC
//   busy_o         not idle, or results still outstanding
//   outstanding_o  dot products issued but not yet returned
//   err_o          sticky protocol error
module posit_mac_feeder
  import posit_mac_pkg::*;
#(
  parameter  int unsigned WIDTH   = WIDTH_DEF,
  parameter  int unsigned K       = K_DEF,
  parameter  int unsigned GAP     = MAC_DRAIN,
  parameter  int unsigned MAX_OUT = 2,
  localparam int unsigned WO      = $clog2(MAX_OUT + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             w_load_i,
  input  logic             w_vld_i,
  input  logic [WIDTH-1:0] w_data_i,
  input  logic             a_vld_i,
  input  logic [WIDTH-1:0] a_data_i,
  output logic             a_rdy_o,
  input  logic             mac_vld_i,
  output logic             vld_o,
  output logic [WIDTH-1:0] win_o,
  output logic [WIDTH-1:0] din_o,
  output logic             busy_o,
  output logic [WO-1:0]    outstanding_o,
  output logic             err_o
);

  localparam int unsigned WK = $clog2(K);
  localparam int unsigned WG = $clog2(GAP + 1);

  feeder_state_e    state;
  logic [WK-1:0]    idx;
  logic [WG-1:0]    gap_cnt;
  logic             wv;
  logic             pend_load;

  logic             accept_c;
  logic             fill_last_c;
  logic             burst_last_c;
  logic             ret_c;
  logic             w_we_c;
  logic             rdy_next_c;
  logic [WK-1:0]    rd_addr_c;
  logic [WO-1:0]    out_next_c;
  logic [WIDTH-1:0] w_rd_c;
  logic [WIDTH-1:0] a_rd_c;

  assign accept_c     = (state == ST_FILL) && a_vld_i && a_rdy_o;
  assign fill_last_c  = accept_c && (idx == WK'(K - 1));
  assign burst_last_c = (state == ST_BURST) && (idx == WK'(K - 1));
  assign w_we_c       = (state == ST_LOAD_W) && w_vld_i;

  // A return coinciding with a burst end is legal even at zero outstanding
  assign ret_c = mac_vld_i && ((outstanding_o != '0) || burst_last_c);

  // Outstanding count as it will be after this edge
  always_comb begin
    out_next_c = outstanding_o;
    if (burst_last_c && !ret_c) begin
      out_next_c = outstanding_o + WO'(1);
    end else if (!burst_last_c && ret_c) begin
      out_next_c = outstanding_o - WO'(1);
    end
  end

  assign rdy_next_c = (out_next_c < WO'(MAX_OUT));

  // Fill reads entry 0 so beat 0 is ready at the last accept; burst prefetches j+1
  assign rd_addr_c = (state == ST_BURST && !burst_last_c) ? (idx + WK'(1)) : '0;

  posit_mac_regfile #(.WIDTH(WIDTH), .DEPTH(K)) u_wreg (
    .clk     (clk_i),
    .we      (w_we_c),
    .waddr   (idx),
    .wdata   (w_data_i),
    .raddr   (rd_addr_c),
    .rdata_c (w_rd_c)
  );

  posit_mac_regfile #(.WIDTH(WIDTH), .DEPTH(K)) u_areg (
    .clk     (clk_i),
    .we      (accept_c),
    .waddr   (idx),
    .wdata   (a_data_i),
    .raddr   (rd_addr_c),
    .rdata_c (a_rd_c)
  );

  // Sequencer: state, indices, counters and all registered outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= ST_IDLE;
      idx           <= '0;
      gap_cnt       <= '0;
      wv            <= 1'b0;
      pend_load     <= 1'b0;
      a_rdy_o       <= 1'b0;
      vld_o         <= 1'b0;
      win_o         <= '0;
      din_o         <= '0;
      busy_o        <= 1'b0;
      outstanding_o <= '0;
      err_o         <= 1'b0;
    end else begin
      outstanding_o <= out_next_c;
      a_rdy_o       <= 1'b0;
      vld_o         <= 1'b0;
      busy_o        <= 1'b1;

      // Result strobe with nothing in flight
      if (mac_vld_i && !ret_c) begin
        err_o <= 1'b1;
      end

      // Weight load requests during issue/drain are deferred to gap exit
      if ((state == ST_BURST || state == ST_GAP) && w_load_i) begin
        pend_load <= 1'b1;
      end

      case (state)
        ST_IDLE: begin
          idx <= '0;
          if (w_load_i) begin
            state <= ST_LOAD_W;
          end else if (wv) begin
            state   <= ST_FILL;
            a_rdy_o <= rdy_next_c;
          end else begin
            busy_o <= (out_next_c != '0);
          end
        end

        ST_LOAD_W: begin
          if (w_load_i) begin
            err_o <= 1'b1;
          end
          if (w_vld_i) begin
            if (idx == WK'(K - 1)) begin
              idx     <= '0;
              wv      <= 1'b1;
              state   <= ST_FILL;
              a_rdy_o <= rdy_next_c;
            end else begin
              idx <= idx + WK'(1);
            end
          end
        end

        ST_FILL: begin
          // A load is only honoured before the first activation lands
          if (w_load_i && !(idx == '0 && !accept_c)) begin
            err_o <= 1'b1;
          end
          if (fill_last_c) begin
            state <= ST_BURST;
            idx   <= '0;
            vld_o <= 1'b1;
            win_o <= w_rd_c;
            din_o <= a_rd_c;
          end else if (w_load_i && idx == '0 && !accept_c) begin
            state <= ST_LOAD_W;
          end else begin
            if (accept_c) begin
              idx <= idx + WK'(1);
            end
            a_rdy_o <= rdy_next_c;
          end
        end

        ST_BURST: begin
          if (burst_last_c) begin
            state   <= ST_GAP;
            gap_cnt <= '0;
          end else begin
            vld_o <= 1'b1;
            win_o <= w_rd_c;
            din_o <= a_rd_c;
            idx   <= idx + WK'(1);
          end
        end

        ST_GAP: begin
          if (gap_cnt == WG'(GAP - 1)) begin
            idx <= '0;
            if (pend_load || w_load_i) begin
              state     <= ST_LOAD_W;
              pend_load <= 1'b0;
            end else begin
              state   <= ST_FILL;
              a_rdy_o <= rdy_next_c;
            end
          end else begin
            gap_cnt <= gap_cnt + WG'(1);
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
